// File: rtl/psubsb_seq_16b_pkg.sv
// Shared constants, FSM encoding and the 1-bit full adder used by the
// packed saturating nibble subtract unit.
package psubsb_seq_16b_pkg;

  localparam int LANE_W = 4;
  localparam int LANES  = 4;
  localparam int DATA_W = LANE_W * LANES;
  localparam int CNT_W  = $clog2(LANES);

  localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_adder_1b(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/psubsb_seq_16b_if.sv
// Request/result bundle between the EX stage and the packed subtract unit.
// The master drives operands and start; the slave returns busy/done and results.
interface psubsb_seq_16b_if;
  import psubsb_seq_16b_pkg::*;

  logic              start;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] S;
  logic [LANES-1:0]  sat;

  modport master (
    output start, A, B,
    input  busy, done, S, sat
  );

  modport slave (
    input  start, A, B,
    output busy, done, S, sat
  );

endinterface

// File: rtl/psubsb_seq_16b_satsub.sv
// Single-lane signed saturating subtractor: ripple of full adders on a + ~b + 1,
// clamped to [-8,+7]; overflow is the carry into vs. out of the sign bit.
module satsub_4b
  import psubsb_seq_16b_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] d,
  output logic              ovf
);

  logic [LANE_W:0]   w_c;
  logic [LANE_W-1:0] w_b_n;
  logic [LANE_W-1:0] w_raw;

  assign w_b_n  = ~b;
  assign w_c[0] = 1'b1;

  for (genvar i = 0; i < LANE_W; i++) begin : g_fa
    assign {w_c[i+1], w_raw[i]} = full_adder_1b(a[i], w_b_n[i], w_c[i]);
  end

  // On overflow the true result has the sign of a, so a[3] picks the clamp.
  assign ovf = w_c[LANE_W] ^ w_c[LANE_W-1];
  assign d   = ovf ? (a[LANE_W-1] ? SAT_NEG : SAT_POS) : w_raw;

endmodule

// File: rtl/psubsb_seq_16b.sv
// Multicycle packed saturating nibble subtract: one lane per clock, four lanes,
// started by a pulse, reports busy during lane writes and a one-cycle done.
module psubsb_seq_16b
  import psubsb_seq_16b_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  psubsb_seq_16b_if.slave    bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_lane_cnt;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_s;
  logic [LANES-1:0]   r_sat;

  logic               w_accept;
  logic               w_last_lane;
  logic [LANE_W-1:0]  w_lane_a;
  logic [LANE_W-1:0]  w_lane_b;
  logic [LANE_W-1:0]  w_lane_d;
  logic               w_lane_ovf;

  // start is honoured only outside RUN, so DONE can chain straight into a new op.
  assign w_accept    = bus.start && (r_state != ST_RUN);
  assign w_last_lane = (r_lane_cnt == CNT_W'(LANES - 1));

  assign w_lane_a = r_a[int'(r_lane_cnt) * LANE_W +: LANE_W];
  assign w_lane_b = r_b[int'(r_lane_cnt) * LANE_W +: LANE_W];

  satsub_4b u_satsub (
    .a   (w_lane_a),
    .b   (w_lane_b),
    .d   (w_lane_d),
    .ovf (w_lane_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  w_state_nxt = w_last_lane ? ST_DONE : ST_RUN;
      ST_DONE: w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane_cnt <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_s        <= '0;
      r_sat      <= '0;
    end else if (w_accept) begin
      r_lane_cnt <= '0;
      r_a        <= bus.A;
      r_b        <= bus.B;
      r_s        <= '0;
      r_sat      <= '0;
    end else if (r_state == ST_RUN) begin
      r_s[int'(r_lane_cnt) * LANE_W +: LANE_W] <= w_lane_d;
      r_sat[r_lane_cnt]                        <= w_lane_ovf;
      r_lane_cnt                               <= r_lane_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.busy = (r_state == ST_RUN);
    bus.done = (r_state == ST_DONE);
    bus.S    = r_s;
    bus.sat  = r_sat;
  end

endmodule
